// File: rtl/isp_vid_gen.sv
// Raw video test source: vsync/back porch/active/front porch timing with href and a synthetic pattern.
// Optional macro ISP_VID_GEN_MOVING_EN adds a per-frame counter that scrolls patterns 1 and 2.
//
// state    | meaning
// S_IDLE   | no frame in progress, waiting for enable
// S_VSYNC  | vsync line periods
// S_VBACK  | blank lines between vsync and first active line
// S_ACTIVE | active lines, href for the first WIDTH clocks of each
// S_VFRONT | blank lines after the last active line
module isp_vid_gen #(
  parameter int BITS         = 8,
  parameter int WIDTH        = 1280,
  parameter int HEIGHT       = 960,
  parameter int HBLANK       = 160,
  parameter int VSYNC_LINES  = 2,
  parameter int VBACK_LINES  = 4,
  parameter int VFRONT_LINES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            single,
  input  logic [1:0]      pattern_sel,
  input  logic [BITS-1:0] flat_value,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_raw,
  output logic            busy,
  output logic            frame_done
);

  localparam int LINE = WIDTH + HBLANK;
  localparam int HW   = $clog2(LINE);
  localparam int VW   = $clog2(VSYNC_LINES + VBACK_LINES + HEIGHT + VFRONT_LINES + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(LINE - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(WIDTH);
  localparam logic [VW-1:0] VS_LAST  = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] VB_LAST  = VW'(VBACK_LINES - 1);
  localparam logic [VW-1:0] ACT_LAST = VW'(HEIGHT - 1);
  localparam logic [VW-1:0] VF_LAST  = VW'(VFRONT_LINES - 1);
  localparam longint MAXV = (longint'(1) << BITS) - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            line_end;
  logic            start_frame;
  logic            frame_end;
  logic            href_c;
  logic [1:0]      pat_q;
  logic [BITS-1:0] flat_q;
  logic            single_q;
  logic            single_hold;
  logic [BITS-1:0] x_b;
  logic [BITS-1:0] bar_val;
  logic [BITS-1:0] pix_c;
  logic            chk_hi;

`ifdef ISP_VID_GEN_MOVING_EN
  logic [BITS-1:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt + BITS'(1);
    end
  end
`endif

  assign line_end = (h_cnt == H_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    frame_end   = 1'b0;
    href_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && !single_hold) begin
          state_d     = S_VSYNC;
          start_frame = 1'b1;
        end
      end
      S_VSYNC: begin
        if (line_end && v_cnt == VS_LAST) begin
          state_d = (VBACK_LINES > 0) ? S_VBACK : S_ACTIVE;
        end
      end
      S_VBACK: begin
        if (line_end && v_cnt == VB_LAST) begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        href_c = (h_cnt < H_ACT);
        if (line_end && v_cnt == ACT_LAST) begin
          if (VFRONT_LINES > 0) begin
            state_d = S_VFRONT;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      S_VFRONT: begin
        if (line_end && v_cnt == VF_LAST) begin
          frame_end = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (frame_end) begin
      if (single_q || !enable) begin
        state_d = S_IDLE;
      end else begin
        state_d     = S_VSYNC;
        start_frame = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (start_frame || state_q == S_IDLE) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= line_end ? '0 : h_cnt + HW'(1);
      if (state_d != state_q) begin
        v_cnt <= '0;
      end else if (line_end) begin
        v_cnt <= v_cnt + VW'(1);
      end
    end
  end

  // Frame configuration is frozen at vsync entry so a frame never mixes patterns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q    <= '0;
      flat_q   <= '0;
      single_q <= 1'b0;
    end else if (start_frame) begin
      pat_q    <= pattern_sel;
      flat_q   <= flat_value;
      single_q <= single;
    end
  end

  // After a single frame, enable must drop before another frame can start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      single_hold <= 1'b0;
    end else if (frame_end && single_q) begin
      single_hold <= 1'b1;
    end else if (!enable) begin
      single_hold <= 1'b0;
    end
  end

  always_comb begin
    bar_val = '0;
    for (int k = 0; k < 8; k++) begin
      if (int'(h_cnt) * 8 >= k * WIDTH) begin
        bar_val = BITS'((longint'(k) * MAXV) / 7);
      end
    end
  end

  always_comb begin
`ifdef ISP_VID_GEN_MOVING_EN
    x_b    = BITS'(h_cnt) + frame_cnt;
    chk_hi = (((int'(h_cnt) + (int'(frame_cnt) & 15)) & 8) != 0) ^ ((int'(v_cnt) & 8) != 0);
`else
    x_b    = BITS'(h_cnt);
    chk_hi = ((int'(h_cnt) & 8) != 0) ^ ((int'(v_cnt) & 8) != 0);
`endif
    case (pat_q)
      2'd0:    pix_c = flat_q;
      2'd1:    pix_c = x_b;
      2'd2:    pix_c = chk_hi ? flat_q : '0;
      default: pix_c = bar_val;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_href   <= 1'b0;
      out_vsync  <= 1'b0;
      out_raw    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_href   <= href_c;
      out_vsync  <= (state_q == S_VSYNC);
      out_raw    <= href_c ? pix_c : '0;
      busy       <= (state_q != S_IDLE);
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_isp_vid_gen.sv
// Bench for isp_vid_gen: frame-position reference model, directed timing/pattern cases, random config churn.
module tb_isp_vid_gen;

  localparam int BITS = 8;
  localparam int W = 8, H = 4, HB = 4, VS = 1, VB = 1, VF = 1;
  localparam int L = W + HB;
  localparam int F = (VS + VB + H + VF) * L;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0, single = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] flat_value = 8'h00;
  logic       out_href, out_vsync, busy, frame_done;
  logic [7:0] out_raw;

  logic       enable2 = 1'b0, single2 = 1'b0;
  logic [1:0] pattern2 = 2'd0;
  logic [7:0] flat2 = 8'h00;
  logic       out_href2, out_vsync2, busy2, frame_done2;
  logic [7:0] out_raw2;

  isp_vid_gen #(.BITS(BITS), .WIDTH(W), .HEIGHT(H), .HBLANK(HB),
                .VSYNC_LINES(VS), .VBACK_LINES(VB), .VFRONT_LINES(VF)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .single(single),
    .pattern_sel(pattern_sel), .flat_value(flat_value),
    .out_href(out_href), .out_vsync(out_vsync), .out_raw(out_raw),
    .busy(busy), .frame_done(frame_done));

  isp_vid_gen #(.BITS(8), .WIDTH(16), .HEIGHT(16), .HBLANK(4),
                .VSYNC_LINES(1), .VBACK_LINES(1), .VFRONT_LINES(1)) dut_chk (
    .clk(clk), .rst_n(rst_n), .enable(enable2), .single(single2),
    .pattern_sel(pattern2), .flat_value(flat2),
    .out_href(out_href2), .out_vsync(out_vsync2), .out_raw(out_raw2),
    .busy(busy2), .frame_done(frame_done2));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0, last_done = -1;
  bit chk_period = 0;
  int href_q[$];
  int bars[8] = '{0, 36, 72, 109, 145, 182, 218, 255};

  // Reference model: position within the frame (-1 when idle) plus frozen config.
  int pos = -1, m_pat = 0, m_flat = 0, m_single = 0, m_hold = 0, m_fc = 0;
  int e_href, e_vsync, e_raw, e_busy, e_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pix(int pat, int flat, int x, int y, int fc);
    case (pat)
      0: return flat;
      1: return (x + fc) % 256;
      2: return ((((x + fc % 16) / 8) % 2) != ((y / 8) % 2)) ? flat : 0;
      default: return (((x * 8) / W) * 255) / 7;
    endcase
  endfunction

  task automatic latch_cfg();
    m_pat = pattern_sel; m_flat = flat_value; m_single = single;
  endtask

  task automatic step_model();
    int line, col, sng;
    bit at_end;
    if (!rst_n) begin
      e_href = 0; e_vsync = 0; e_raw = 0; e_busy = 0; e_done = 0;
      pos = -1; m_hold = 0; m_fc = 0;
      return;
    end
    if (pos < 0) begin
      e_href = 0; e_vsync = 0; e_raw = 0; e_busy = 0; e_done = 0;
    end else begin
      line = pos / L; col = pos % L;
      e_busy = 1;
      e_vsync = (line < VS);
      e_href = (line >= VS + VB) && (line < VS + VB + H) && (col < W);
      e_raw = e_href ? pix(m_pat, m_flat, col, line - VS - VB, m_fc) : 0;
      e_done = (pos == F - 1);
    end
    sng = m_single;
    at_end = (pos == F - 1);
    if (pos < 0) begin
      if (enable && m_hold == 0) begin pos = 0; latch_cfg(); end
    end else if (at_end) begin
`ifdef ISP_VID_GEN_MOVING_EN
      m_fc++;
`endif
      if (sng != 0 || !enable) pos = -1;
      else begin pos = 0; latch_cfg(); end
    end else begin
      pos++;
    end
    if (at_end && sng != 0) m_hold = 1;
    else if (!enable) m_hold = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    step_model();
    @(negedge clk);
    cyc++;
    chk("href", out_href, e_href);
    chk("vsync", out_vsync, e_vsync);
    chk("raw", out_raw, e_raw);
    chk("busy", busy, e_busy);
    chk("frame_done", frame_done, e_done);
    if (chk_period && frame_done) begin
      if (last_done >= 0) chk("done_period", cyc - last_done, F);
      last_done = cyc;
    end
    if (out_href) href_q.push_back(out_raw);
  endtask

  task automatic run_until_done(input string tag, input int max);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      cycle();
      if (frame_done) seen = 1;
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    int ndone;
    int q2[$];
    repeat (3) @(negedge clk);
    chk("rst_href", out_href, 0);
    chk("rst_vsync", out_vsync, 0);
    chk("rst_raw", out_raw, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    rst_n = 1'b1;
    repeat (3) cycle();

    // continuous gradient frames
    pattern_sel = 2'd1; flat_value = 8'h3C; enable = 1'b1;
    cycle(); chk("vsync_lat_a", out_vsync, 0);
    cycle(); chk("vsync_lat_b", out_vsync, 1);
    chk_period = 1; last_done = -1;
    repeat (3 * F) cycle();
    chk_period = 0;

    // gray bars, with a pattern change mid-frame that must not take effect
    pattern_sel = 2'd3;
    run_until_done("bars_sync", 2 * F);
    href_q.delete();
    for (int i = 0; i < F; i++) begin
      cycle();
      if (i == 40) begin pattern_sel = 2'd0; flat_value = 8'h11; end
    end
    chk("bars_count", href_q.size(), 4 * W);
    foreach (href_q[i]) chk("bars_px", href_q[i], bars[i % 8]);

    // disable on active line 2: frame finishes then idles
    repeat (50) cycle();
    enable = 1'b0;
    run_until_done("disable_done", F);
    repeat (5) cycle();
    chk("disable_idle", busy, 0);

    // single frame with enable held
    single = 1'b1; enable = 1'b1; pattern_sel = 2'd1;
    ndone = 0;
    for (int i = 0; i < F + 210; i++) begin
      cycle();
      if (frame_done) ndone++;
    end
    chk("single_count", ndone, 1);
    chk("single_busy", busy, 0);

    // asynchronous reset mid-line
    single = 1'b0; enable = 1'b0;
    cycle();
    enable = 1'b1;
    repeat (45) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_href", out_href, 0);
    chk("rstmid_vsync", out_vsync, 0);
    chk("rstmid_raw", out_raw, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", frame_done, 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    cycle(); chk("restart_vsync", out_vsync, 1);

    // random configuration churn
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if ($urandom_range(0, 19) == 0) pattern_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) flat_value = 8'($urandom);
      if ($urandom_range(0, 199) == 0) single = ~single;
      if ($urandom_range(0, 149) == 0) enable = ~enable;
    end

    // checkerboard on the 16x16 instance
    enable2 = 1'b1; single2 = 1'b1; pattern2 = 2'd2; flat2 = 8'hA5;
    for (int i = 0; i < 500; i++) begin
      cycle();
      if (out_href2) q2.push_back(out_raw2);
    end
    chk("chk_count", q2.size(), 256);
    foreach (q2[i]) chk("chk_px", q2[i], (((i % 16) / 8) != ((i / 16) / 8)) ? 8'hA5 : 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not reach summary, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
